// File: rtl/seq_shifter.sv
// Multi-cycle barrel shifter: one binary stage of the shift amount per cycle, fixed SHW-cycle latency.
// Optional macro SEQ_SHIFTER_ROTATE_EN makes op=11 a rotate-left; otherwise op=11 behaves as SLL.
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   k_q, k_d;
  logic [1:0]       op_q, op_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [SHW-1:0]   stage_amt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] stage_res;
`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam logic [SHW:0] WIDTH_L = (SHW+1)'(WIDTH);
  logic [SHW:0]     rot_amt;
`endif

  // Working register shifted by 2^k according to the captured operation
  always_comb begin
    stage_amt = SHW'(1) << k_q;
    shifted   = work_q << stage_amt;
`ifdef SEQ_SHIFTER_ROTATE_EN
    rot_amt   = WIDTH_L - {1'b0, stage_amt};
`endif
    case (op_q)
      2'b01:   shifted = work_q >> stage_amt;
      2'b10:   shifted = $unsigned($signed(work_q) >>> stage_amt);
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11:   shifted = (work_q << stage_amt) | (work_q >> rot_amt);
`endif
      default: shifted = work_q << stage_amt;
    endcase
    // shamt_q is consumed LSB-first, so bit 0 is always the current stage's bit
    stage_res = shamt_q[0] ? shifted : work_q;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    op_d        = op_q;
    shamt_d     = shamt_q;
    work_d      = work_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          shamt_d = shamt;
          work_d  = number;
          k_d     = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = stage_res;
        shamt_d = shamt_q >> 1;
        k_d     = k_q + SHW'(1);
        if (k_q == SHW'(SHW - 1)) begin
          out_d       = stage_res;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      op_q        <= '0;
      shamt_q     <= '0;
      work_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      op_q        <= op_d;
      shamt_q     <= shamt_d;
      work_q      <= work_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: driver pushes expected results, a negedge monitor pops and checks them.
module tb_seq_shifter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;

  logic             clock, reset;
  logic             in_valid, in_ready;
  logic [1:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] number;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] dout;

  seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .shamt(shamt), .number(number), .out_valid(out_valid),
    .out_ready(out_ready), .out(dout)
  );

  typedef struct {
    logic [31:0] res;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur;
  int   cyc;
  int   checks, passed;
  int   bp_mode;  // 0: always ready, 1: random, 2: held low

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: whole shift done in one step from the operation definitions
  function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] s, input logic [31:0] n);
    logic [31:0] r;
    case (o)
      2'd0: r = n << s;
      2'd1: r = n >> s;
      2'd2: r = 32'($signed(n) >>> s);
      default: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
        r = n;
        for (int i = 0; i < int'(s); i++) r = {r[30:0], r[31]};
`else
        r = n << s;
`endif
      end
    endcase
    return r;
  endfunction

  // Monitor: pop on the first valid cycle, then check every valid cycle until handshake
  always @(negedge clock) begin
    if (reset) begin
      have_cur = 1'b0;
    end else if (out_valid) begin
      if (!have_cur) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
          cur.res = dout;
          cur.acc = cyc - int'(SHW);
        end else begin
          cur = sb.pop_front();
          check("latency", 32'(cyc - cur.acc), 32'(SHW));
        end
        have_cur = 1'b1;
      end
      check("result", dout, cur.res);
      check("in_ready_busy", 32'(in_ready), 32'd0);
      if (out_ready) have_cur = 1'b0;
    end else if (have_cur) begin
      check("valid_dropped", 32'd0, 32'd1);
      have_cur = 1'b0;
    end
  end

  task automatic do_req(input logic [1:0] o, input logic [4:0] s, input logic [31:0] n,
                        input logic [31:0] exp);
    int t;
    exp_t e;
    t = 0;
    @(negedge clock);
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) check("req_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    op = o; shamt = s; number = n;
    e.res = exp;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!out_valid) check(name, 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || have_cur || !in_ready) && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (sb.size() != 0 || have_cur) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [1:0]  o;
    logic [4:0]  s;
    logic [31:0] n;
    int          prev_acc, accepts, t;
    exp_t        e;

    cyc = 0; checks = 0; passed = 0; have_cur = 1'b0; bp_mode = 0;
    reset = 1'b1; in_valid = 1'b0; op = '0; shamt = '0; number = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", dout, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Directed corner operations
    do_req(2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
    do_req(2'b10, 5'd4,  32'h8000_00F0, 32'hF800_000F);
    do_req(2'b01, 5'd4,  32'h8000_00F0, 32'h0800_000F);
`ifdef SEQ_SHIFTER_ROTATE_EN
    do_req(2'b11, 5'd1,  32'h8000_0001, 32'h0000_0003);
`else
    do_req(2'b11, 5'd1,  32'h8000_0001, 32'h0000_0002);
`endif
    do_req(2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
    do_req(2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001);
    drain();

    // Zero shift under backpressure
    bp_mode = 2;
    @(negedge clock);
    do_req(2'b00, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wait_valid("bp_valid_timeout");
    repeat (10) begin
      @(negedge clock);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    bp_mode = 0;
    t = 0;
    while (!(out_valid && out_ready) && t < 20) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset two cycles into SHIFT, then accept on first edge after release
    do_req(2'b00, 5'd3, 32'h1234_5678, 32'h91A2_B3C0);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", dout, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b1; op = 2'b01; shamt = 5'd8; number = 32'hCAFE_F00D;
    e.res = 32'h00CA_FEF0; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    check("post_rst_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid held high; extra pulses while busy are dropped
    prev_acc = 0; accepts = 0; t = 0;
    @(negedge clock);
    in_valid = 1'b1;
    while (accepts < 5 && t < 100) begin
      o = 2'($urandom_range(0, 3)); s = 5'($urandom); n = $urandom;
      op = o; shamt = s; number = n;
      if (in_ready) begin
        e.res = model(o, s, n); e.acc = cyc + 1;
        sb.push_back(e);
        if (accepts > 0) check("b2b_interval", 32'(e.acc - prev_acc), 32'(SHW + 2));
        prev_acc = e.acc;
        accepts++;
      end
      @(negedge clock);
      t++;
    end
    if (accepts < 5) check("b2b_timeout", 32'(accepts), 32'd5);
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      s = (i % 8 == 0) ? 5'd0 : 5'($urandom);
      n = $urandom;
      do_req(o, s, n, model(o, s, n));
    end
    bp_mode = 0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; must be a power of two, minimum 4.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width; equals log2(WIDTH).
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port op, input, 2, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-008 SHALL have port shamt, input, SHW, shift amount.
REQ-009 SHALL have port number, input, WIDTH, operand.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port out, output, WIDTH, result.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE.
REQ-014 SHALL assert in_ready only in IDLE; in_ready is a registered function of state only.
REQ-015 SHALL, in IDLE with in_valid=1, capture op, shamt and number, clear stage counter k, and enter SHIFT.
REQ-016 SHALL, in each SHIFT cycle, shift the working register by 2^k when captured shamt[k]=1, else hold it, then increment k.
REQ-017 SHALL shift in zeros for SLL and SRL, copies of the captured operand MSB for SRA, and wrap bits MSB-to-LSB for ROL.
REQ-018 SHALL leave SHIFT for DONE after the stage with k=SHW-1, giving fixed latency SHW cycles from the accept edge to out_valid=1, independent of shamt.
REQ-019 SHALL, in DONE, assert out_valid=1 and hold out stable until out_ready=1.
REQ-020 SHALL, in DONE with out_ready=1, return to IDLE; out_valid falls on the next edge.
REQ-021 SHALL ignore in_valid outside IDLE; no request is queued.
REQ-022 SHALL produce out equal to number when shamt=0, after full latency.
REQ-023 SHALL treat shamt as unsigned; the maximum shift is WIDTH-1, and no shift produces an all-fill result except through that value.
REQ-024 SHALL hold out at its last result in IDLE and SHIFT; out is meaningful only while out_valid=1.

Reset
REQ-025 SHALL, on reset=1, immediately force state IDLE, k=0, working register 0, out=0, out_valid=0 and in_ready=1, without waiting for a clock edge.
REQ-026 SHALL abandon any in-flight operation on reset, including in SHIFT and DONE, and produce no result after reset release.
REQ-027 SHALL accept a request on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL honour macro SEQ_SHIFTER_ROTATE_EN.
REQ-029 SHALL, with SEQ_SHIFTER_ROTATE_EN defined, execute op=11 as rotate-left per REQ-017.
REQ-030 SHALL, without SEQ_SHIFTER_ROTATE_EN, execute op=11 as SLL and synthesise no wrap logic.

Verification
REQ-031 SHALL cover SLL: WIDTH=32, number=0x0000_0001, shamt=31, op=00 -> out=0x8000_0000, out_valid=1 exactly 5 cycles after the accept edge.
REQ-032 SHALL cover SRA: number=0x8000_00F0, shamt=4, op=10 -> out=0xF800_000F. Same operation with op=01 -> out=0x0800_000F.
REQ-033 SHALL cover ROL, with macro defined: number=0x8000_0001, shamt=1, op=11 -> out=0x0000_0003. Without macro -> out=0x0000_0002.
REQ-034 SHALL cover zero shift and backpressure: shamt=0, number=0xDEAD_BEEF, out_ready held 0 for 10 cycles -> out=0xDEAD_BEEF stable with out_valid=1 throughout, in_ready=0. Then out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover reset mid-operation: assert reset asynchronously 2 cycles into SHIFT -> out_valid=0, out=0, in_ready=1 before the next edge, and no stale result after release.
REQ-036 SHALL cover back-to-back requests: in_valid held 1 with out_ready=1 -> one request accepted every SHW+2 cycles, and in_valid pulses during SHIFT are dropped.
